// File: rtl/dsp_file_buffer.sv
// dsp_file_buffer: circular word buffer shared by a host push/pop port and an
// equation-engine file port. Define DSP_FILE_BUFFER_LEVEL_EN to add the level output.
module dsp_file_buffer #(
    parameter int         dw         = 32,
    parameter int         DEPTH_LOG2 = 6,
    parameter logic [7:0] FILE_ID    = 8'h00
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic          host_wr_en,
    input  logic [dw-1:0] host_wr_data,
    input  logic          host_rd_en,
    output logic [dw-1:0] host_rd_data,
    input  logic [7:0]    file_num,
    input  logic          file_read,
    input  logic          file_write,
    input  logic [31:0]   file_write_data,
    output logic [31:0]   file_read_data,
    output logic          file_active,
    output logic [31:0]   rd_ptr,
    output logic [31:0]   wr_ptr,
    output logic          overflow,
    output logic          underflow
`ifdef DSP_FILE_BUFFER_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_ACTIVE = 3'd1;
    localparam logic [2:0] S_RD_HOLD   = 3'd2;
    localparam logic [2:0] S_WR_ACTIVE = 3'd3;
    localparam logic [2:0] S_RELEASE   = 3'd4;

    logic [dw-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2:0]   rd_p, wr_p, rd_p_nxt, wr_p_nxt;
    logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
    logic [2:0]            state, state_nxt;
    logic                  empty, full, selected;
    logic                  rd_start, wr_start, rd_busy;
    logic                  host_pop, eng_pop, pop_any;
    logic                  host_push, eng_push, eng_stall;
    logic                  mem_we, ovf_set, unf_set, active_nxt;
    logic [dw-1:0]         mem_wdata;

    assign rd_idx   = rd_p[DEPTH_LOG2-1:0];
    assign wr_idx   = wr_p[DEPTH_LOG2-1:0];
    assign empty    = (rd_p == wr_p);
    assign full     = (rd_idx == wr_idx) && (rd_p[DEPTH_LOG2] != wr_p[DEPTH_LOG2]);
    assign selected = (file_num == FILE_ID);

    assign rd_start = (state == S_IDLE) && selected && file_read && !empty;
    assign wr_start = (state == S_IDLE) && selected && file_write && !file_read;

    // An engine read owns the head word from the cycle it starts until its pop.
    assign rd_busy  = rd_start || (state == S_RD_ACTIVE) || (state == S_RD_HOLD);
    assign host_pop = host_rd_en && !empty && !rd_busy;
    assign eng_pop  = (state == S_RD_HOLD);
    assign pop_any  = host_pop || eng_pop;

    // Any pop this cycle frees a slot, so a push into a full buffer still lands.
    assign host_push = host_wr_en && (!full || pop_any);
    assign eng_stall = (state == S_WR_ACTIVE) && host_wr_en;
    assign eng_push  = (state == S_WR_ACTIVE) && !host_wr_en && (!full || pop_any);
    assign ovf_set   = full && !pop_any && (host_wr_en || (state == S_WR_ACTIVE));
    assign unf_set   = host_rd_en && empty && !rd_busy;

    assign mem_we    = host_push || eng_push;
    assign mem_wdata = host_push ? host_wr_data : dw'(file_write_data);
    assign rd_p_nxt  = rd_p + {{DEPTH_LOG2{1'b0}}, pop_any};
    assign wr_p_nxt  = wr_p + {{DEPTH_LOG2{1'b0}}, mem_we};

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rd_start)      state_nxt = S_RD_ACTIVE;
                else if (wr_start) state_nxt = S_WR_ACTIVE;
            end
            S_RD_ACTIVE: state_nxt = S_RD_HOLD;
            S_RD_HOLD:   state_nxt = S_RELEASE;
            S_WR_ACTIVE: if (!eng_stall) state_nxt = S_RELEASE;
            S_RELEASE:   if (!file_read && !file_write) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    assign active_nxt = (state_nxt == S_RD_ACTIVE) || (state_nxt == S_RD_HOLD) ||
                        (state_nxt == S_WR_ACTIVE);

    // NOTE: storage array has no reset; its contents are only meaningful once written.
    always_ff @(posedge wb_clk) begin
        if (mem_we) mem[wr_idx] <= mem_wdata;
    end

    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state          <= S_IDLE;
            rd_p           <= '0;
            wr_p           <= '0;
            file_active    <= 1'b0;
            file_read_data <= '0;
            host_rd_data   <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
`ifdef DSP_FILE_BUFFER_LEVEL_EN
            level          <= '0;
`endif
        end else begin
            state        <= state_nxt;
            rd_p         <= rd_p_nxt;
            wr_p         <= wr_p_nxt;
            file_active  <= active_nxt;
            host_rd_data <= mem[rd_idx];
            if (rd_start) file_read_data <= 32'(mem[rd_idx]);
            if (ovf_set)  overflow  <= 1'b1;
            if (unf_set)  underflow <= 1'b1;
`ifdef DSP_FILE_BUFFER_LEVEL_EN
            level        <= wr_p_nxt - rd_p_nxt;
`endif
        end
    end

    assign rd_ptr = 32'(rd_p);
    assign wr_ptr = 32'(wr_p);

endmodule

// File: tb/tb_dsp_file_buffer.sv
// Directed self-checking bench for dsp_file_buffer (default parameters);
// level checks run only when DSP_FILE_BUFFER_LEVEL_EN is defined.
module tb_dsp_file_buffer;

    localparam logic [7:0] FILE_ID = 8'h00;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic        host_wr_en, host_rd_en, file_read, file_write;
    logic [31:0] host_wr_data, host_rd_data, file_write_data, file_read_data;
    logic [7:0]  file_num;
    logic        file_active, overflow, underflow;
    logic [31:0] rd_ptr, wr_ptr;
`ifdef DSP_FILE_BUFFER_LEVEL_EN
    logic [6:0]  level;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int act_cnt;

    dsp_file_buffer #(.dw(32), .DEPTH_LOG2(6), .FILE_ID(FILE_ID)) dut (
        .wb_clk          (wb_clk),
        .wb_rst_n        (wb_rst_n),
        .host_wr_en      (host_wr_en),
        .host_wr_data    (host_wr_data),
        .host_rd_en      (host_rd_en),
        .host_rd_data    (host_rd_data),
        .file_num        (file_num),
        .file_read       (file_read),
        .file_write      (file_write),
        .file_write_data (file_write_data),
        .file_read_data  (file_read_data),
        .file_active     (file_active),
        .rd_ptr          (rd_ptr),
        .wr_ptr          (wr_ptr),
        .overflow        (overflow),
        .underflow       (underflow)
`ifdef DSP_FILE_BUFFER_LEVEL_EN
        ,
        .level           (level)
`endif
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        host_wr_en   = 1'b1;
        host_wr_data = d;
        tick();
        host_wr_en   = 1'b0;
    endtask

    task automatic pop();
        host_rd_en = 1'b1;
        tick();
        host_rd_en = 1'b0;
    endtask

    // Full engine read: ack must appear, stay high two cycles, then drop with rd_ptr advanced.
    task automatic eng_read(input string tag, input logic [31:0] exp_data, input logic [31:0] exp_rd);
        bit got;
        got       = 1'b0;
        file_num  = FILE_ID;
        file_read = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = file_active;
        end
        file_read = 1'b0;
        check({tag, "_ack"}, 32'(got), 32'd1);
        check({tag, "_data"}, file_read_data, exp_data);
        tick();
        check({tag, "_hold"}, 32'(file_active), 32'd1);
        tick();
        check({tag, "_drop"}, 32'(file_active), 32'd0);
        check({tag, "_rdptr"}, rd_ptr, exp_rd);
        tick();
    endtask

    initial begin
        wb_rst_n        = 1'b0;
        host_wr_en      = 1'b0;
        host_rd_en      = 1'b0;
        host_wr_data    = '0;
        file_num        = FILE_ID;
        file_read       = 1'b0;
        file_write      = 1'b0;
        file_write_data = '0;

        // Reset state
        tick();
        tick();
        check("rst_rdptr", rd_ptr, 32'd0);
        check("rst_wrptr", wr_ptr, 32'd0);
        check("rst_active", 32'(file_active), 32'd0);
        check("rst_frd", file_read_data, 32'd0);
        check("rst_hrd", host_rd_data, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        wb_rst_n = 1'b1;
        tick();

        // Host pushes 3,5,7; engine reads them back in order
        push(32'd3);
        push(32'd5);
        push(32'd7);
        check("p3_wrptr", wr_ptr, 32'd3);
        check("p3_hrd", host_rd_data, 32'd3);
        eng_read("rd3", 32'd3, 32'd1);
        eng_read("rd5", 32'd5, 32'd2);
        eng_read("rd7", 32'd7, 32'd3);
        check("rd_eq_wr", wr_ptr, 32'd3);

        // Foreign file number is ignored
        push(32'h99);
        file_num   = 8'h01;
        file_read  = 1'b1;
        file_write = 1'b1;
        tick(); tick(); tick(); tick();
        check("foreign_active", 32'(file_active), 32'd0);
        check("foreign_rdptr", rd_ptr, 32'd3);
        check("foreign_wrptr", wr_ptr, 32'd4);
        check("hrd_99", host_rd_data, 32'h99);
        file_num   = FILE_ID;
        file_read  = 1'b0;
        file_write = 1'b0;
        pop();
        check("hpop_rdptr", rd_ptr, 32'd4);
        check("hpop_unf", 32'(underflow), 32'd0);

        // Pop on empty: underflow, pointer unchanged
        pop();
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_rdptr", rd_ptr, 32'd4);

        // Read request waiting on empty buffer, then data arrives
        file_read = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("empty_wait", 32'(file_active), 32'd0);
        push(32'h55);
        check("push55_noact", 32'(file_active), 32'd0);
        tick();
        check("push55_act", 32'(file_active), 32'd1);
        check("push55_data", file_read_data, 32'h55);
        file_read = 1'b0;
        tick();
        check("push55_hold", 32'(file_active), 32'd1);
        tick();
        check("push55_drop", 32'(file_active), 32'd0);
        check("push55_rdptr", rd_ptr, 32'd5);
        tick();

        // Held request for 6 cycles is serviced once
        push(32'h11);
        push(32'h22);
        act_cnt   = 0;
        file_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (file_active) act_cnt++;
        end
        file_read = 1'b0;
        tick();
        check("held_actcnt", 32'(act_cnt), 32'd2);
        check("held_rdptr", rd_ptr, 32'd6);
        check("held_data", file_read_data, 32'h11);
        tick();
        check("held_idle", 32'(file_active), 32'd0);

        // Engine write, held request not repeated
        file_write_data = 32'hABCD_1234;
        file_write      = 1'b1;
        tick();
        check("ewr_act", 32'(file_active), 32'd1);
        tick();
        check("ewr_drop", 32'(file_active), 32'd0);
        check("ewr_wrptr", wr_ptr, 32'd8);
        tick();
        check("ewr_once", wr_ptr, 32'd8);
        file_write = 1'b0;
        tick();

        // Read and write together: read wins
        file_read  = 1'b1;
        file_write = 1'b1;
        tick();
        check("both_act", 32'(file_active), 32'd1);
        check("both_data", file_read_data, 32'h22);
        file_read  = 1'b0;
        file_write = 1'b0;
        tick();
        tick();
        check("both_rdptr", rd_ptr, 32'd7);
        check("both_wrptr", wr_ptr, 32'd8);
        tick();

        // Host push collides with engine write: host first, engine stalls one cycle
        file_write_data = 32'h0E0E;
        file_write      = 1'b1;
        tick();
        check("stall_act0", 32'(file_active), 32'd1);
        host_wr_en   = 1'b1;
        host_wr_data = 32'h0F0F;
        tick();
        host_wr_en = 1'b0;
        check("stall_act1", 32'(file_active), 32'd1);
        check("stall_wrptr1", wr_ptr, 32'd9);
        tick();
        check("stall_drop", 32'(file_active), 32'd0);
        check("stall_wrptr2", wr_ptr, 32'd10);
        file_write = 1'b0;
        tick();
        eng_read("rdA", 32'hABCD_1234, 32'd8);
        eng_read("rdF", 32'h0F0F, 32'd9);
        eng_read("rdE", 32'h0E0E, 32'd10);
        check("unf_sticky", 32'(underflow), 32'd1);

        // Asynchronous reset during RD_HOLD
        push(32'h77);
        file_read = 1'b1;
        tick();
        check("arst_act", 32'(file_active), 32'd1);
        file_read = 1'b0;
        tick();
        check("arst_hold", 32'(file_active), 32'd1);
        #2 wb_rst_n = 1'b0;
        #1;
        check("arst_active", 32'(file_active), 32'd0);
        check("arst_rdptr", rd_ptr, 32'd0);
        check("arst_wrptr", wr_ptr, 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_unf", 32'(underflow), 32'd0);
        tick();
        wb_rst_n = 1'b1;
        tick();

        // Fill to 64, overflow on the 65th
        host_wr_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            host_wr_data = 32'h100 + 32'(i);
            tick();
        end
        host_wr_en = 1'b0;
        check("full_wrptr", wr_ptr, 32'h40);
        check("full_noovf", 32'(overflow), 32'd0);
        push(32'hDEAD);
        check("ovf_wrptr", wr_ptr, 32'h40);
        check("ovf_set", 32'(overflow), 32'd1);
        eng_read("rd_w0", 32'h100, 32'd1);

        // Push and pop together while full
        push(32'h200);
        check("refull_wrptr", wr_ptr, 32'h41);
        host_wr_en   = 1'b1;
        host_wr_data = 32'h201;
        host_rd_en   = 1'b1;
        tick();
        host_wr_en = 1'b0;
        host_rd_en = 1'b0;
        check("pp_full_rdptr", rd_ptr, 32'd2);
        check("pp_full_wrptr", wr_ptr, 32'h42);

`ifdef DSP_FILE_BUFFER_LEVEL_EN
        wb_rst_n = 1'b0;
        tick();
        wb_rst_n = 1'b1;
        tick();
        check("lvl_rst", 32'(level), 32'd0);
        for (int i = 0; i < 5; i++) push(32'(i));
        pop();
        pop();
        check("lvl_3", 32'(level), 32'd3);
        host_wr_en   = 1'b1;
        host_wr_data = 32'h33;
        host_rd_en   = 1'b1;
        tick();
        host_wr_en = 1'b0;
        host_rd_en = 1'b0;
        check("lvl_pp", 32'(level), 32'd3);
        check("lvl_pp_wr", wr_ptr, 32'd6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
